intersection_scheduler: RTL and testbench

Two-approach traffic intersection controller that shares one crossing between the north-south (NS) and east-west (EW) signal heads. It sequences green, yellow and all-red clearance phases with a single down-counter. It latches pedestrian pass requests per approach and shortens the matching green phase. It sits above the per-lamp drivers and exposes the remaining phase time for the countdown display.

---
 rtl/traffic_pkg.sv | 61 ++++++
 rtl/phase_timer.sv | 36 +++
 rtl/intersection_scheduler.sv | 111 +++++++++++
 tb/tb_intersection_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, default timings and lamp decode
// Used by intersection_scheduler and phase_timer.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR_NS = 3'd1,
    NS_G  = 3'd2,
    NS_Y  = 3'd3,
    AR_EW = 3'd4,
    EW_G  = 3'd5,
    EW_Y  = 3'd6
  } phase_e;

  localparam int unsigned GREEN_T_DEF  = 60;
  localparam int unsigned YELLOW_T_DEF = 5;
  localparam int unsigned ALLRED_T_DEF = 2;
  localparam int unsigned SHORT_T_DEF  = 10;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      AR_NS:   return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR_EW;
      AR_EW:   return EW_G;
      EW_G:    return EW_Y;
      default: return AR_NS;
    endcase
  endfunction

  function automatic lamp_t ns_lamp(input phase_e p);
    lamp_t l;
    l = '0;
    case (p)
      IDLE:    l = '0;
      NS_G:    l.green = 1'b1;
      NS_Y:    l.yellow = 1'b1;
      default: l.red = 1'b1;
    endcase
    return l;
  endfunction

  function automatic lamp_t ew_lamp(input phase_e p);
    lamp_t l;
    l = '0;
    case (p)
      IDLE:    l = '0;
      EW_G:    l.green = 1'b1;
      EW_Y:    l.yellow = 1'b1;
      default: l.red = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - 8-bit loadable phase down-counter with shorten-to-SHORT_T
// Holds at 1 rather than wrapping; o_done flags the last cycle of a phase.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [7:0] SHORT_T = 8'(SHORT_T_DEF)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_shorten,
  output logic [7:0] o_count,
  output logic       o_done
);

  logic [7:0] r_count;
  logic       w_above_short;

  assign w_above_short = (r_count > SHORT_T);
  assign o_done        = (r_count == 8'd1);
  assign o_count       = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_shorten && w_above_short) begin
      r_count <= SHORT_T;
    end else if (r_count > 8'd1) begin
      r_count <= r_count - 8'd1;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - NS/EW intersection phase sequencer with lamp decode
// Define PASS_SHORTEN_EN to build the pedestrian request latches and green shortening.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = GREEN_T_DEF,
  parameter int unsigned YELLOW_T = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T = ALLRED_T_DEF,
  parameter int unsigned SHORT_T  = SHORT_T_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_pass_request,
  input  logic       ew_pass_request,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [7:0] clock,
  output logic [2:0] phase
);

  phase_e     r_phase;
  phase_e     w_next;
  lamp_t      r_ns_lamp;
  lamp_t      r_ew_lamp;
  logic       w_done;
  logic       w_load;
  logic       w_shorten;
  logic [7:0] w_load_val;

  always_comb begin
    w_next = r_phase;
    if (r_phase == IDLE) begin
      w_next = AR_NS;
    end else if (w_done) begin
      w_next = next_phase(r_phase);
    end
  end

  assign w_load = (r_phase == IDLE) || w_done;

  always_comb begin
    w_load_val = 8'(ALLRED_T);
    case (w_next)
      NS_G, EW_G: w_load_val = 8'(GREEN_T);
      NS_Y, EW_Y: w_load_val = 8'(YELLOW_T);
      default:    w_load_val = 8'(ALLRED_T);
    endcase
  end

`ifdef PASS_SHORTEN_EN
  logic r_ns_req_q;
  logic r_ew_req_q;

  // Clearing on green exit wins over a same-cycle request, so a last-cycle press is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ns_req_q <= 1'b0;
      r_ew_req_q <= 1'b0;
    end else begin
      if (r_phase == NS_G && w_done) r_ns_req_q <= 1'b0;
      else if (ns_pass_request)      r_ns_req_q <= 1'b1;
      if (r_phase == EW_G && w_done) r_ew_req_q <= 1'b0;
      else if (ew_pass_request)      r_ew_req_q <= 1'b1;
    end
  end

  assign w_shorten = (r_phase == NS_G && r_ns_req_q) || (r_phase == EW_G && r_ew_req_q);
`else
  logic w_unused_req;
  assign w_unused_req = ns_pass_request ^ ew_pass_request;
  assign w_shorten    = 1'b0;
`endif

  phase_timer #(
    .SHORT_T(8'(SHORT_T))
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_shorten (w_shorten),
    .o_count   (clock),
    .o_done    (w_done)
  );

  // Lamps decode the next phase so they change on the same edge as phase and clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= IDLE;
      r_ns_lamp <= '0;
      r_ew_lamp <= '0;
    end else begin
      r_phase   <= w_next;
      r_ns_lamp <= ns_lamp(w_next);
      r_ew_lamp <= ew_lamp(w_next);
    end
  end

  assign phase     = r_phase;
  assign ns_red    = r_ns_lamp.red;
  assign ns_yellow = r_ns_lamp.yellow;
  assign ns_green  = r_ns_lamp.green;
  assign ew_red    = r_ew_lamp.red;
  assign ew_yellow = r_ew_lamp.yellow;
  assign ew_green  = r_ew_lamp.green;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - scoreboard bench for intersection_scheduler
// Reference model tracks phase index and remaining cycles; honours PASS_SHORTEN_EN.
module tb_intersection_scheduler;

  localparam int G_T = 60;
  localparam int Y_T = 5;
  localparam int A_T = 2;
  localparam int S_T = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_pass_request = 1'b0;
  logic       ew_pass_request = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [7:0] clock;
  logic [2:0] phase;

  intersection_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ns_pass_request(ns_pass_request),
    .ew_pass_request(ew_pass_request),
    .ns_red         (ns_red),
    .ns_yellow      (ns_yellow),
    .ns_green       (ns_green),
    .ew_red         (ew_red),
    .ew_yellow      (ew_yellow),
    .ew_green       (ew_green),
    .clock          (clock),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int rem;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: phase index 0=IDLE,1=AR_NS,2=NS_G,3=NS_Y,4=AR_EW,5=EW_G,6=EW_Y
  int m_ph = 0;
  int m_rem = 0;
  bit m_nq = 0;
  bit m_eq = 0;

  function automatic int dur(input int p);
    if (p == 2 || p == 5) return G_T;
    if (p == 3 || p == 6) return Y_T;
    return A_T;
  endfunction

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  function automatic logic [5:0] exp_lamps(input int p);
    case (p)
      1, 4:    return 6'b100_100;
      2:       return 6'b001_100;
      3:       return 6'b010_100;
      5:       return 6'b100_001;
      6:       return 6'b100_010;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_advance(input bit ns, input bit ew);
    int  nph;
    int  nrem;
    bit  leave_ns;
    bit  leave_ew;
    bit  short_ok;
    nph = m_ph;
    leave_ns = 0;
    leave_ew = 0;
    short_ok = 0;
`ifdef PASS_SHORTEN_EN
    short_ok = (m_ph == 2 && m_nq) || (m_ph == 5 && m_eq);
`endif
    if (m_ph == 0) begin
      nph  = 1;
      nrem = A_T;
    end else if (m_rem == 1) begin
      nph  = (m_ph == 6) ? 1 : m_ph + 1;
      nrem = dur(nph);
      leave_ns = (m_ph == 2);
      leave_ew = (m_ph == 5);
    end else if (short_ok && m_rem > S_T) begin
      nrem = S_T;
    end else begin
      nrem = m_rem - 1;
    end
`ifdef PASS_SHORTEN_EN
    m_nq = leave_ns ? 1'b0 : (m_nq | ns);
    m_eq = leave_ew ? 1'b0 : (m_eq | ew);
`endif
    m_ph  = nph;
    m_rem = nrem;
  endtask

  task automatic step(input bit ns, input bit ew);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    ns_pass_request = ns;
    ew_pass_request = ew;
    model_advance(ns, ew);
    e.ph  = m_ph;
    e.rem = m_rem;
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int ph, input int rem);
    int n;
    n = 0;
    while (!(m_ph == ph && m_rem == rem) && n < 1000) begin
      step(0, 0);
      n++;
    end
    if (n >= 1000) chk("run_until_timeout", m_ph * 256 + m_rem, ph * 256 + rem);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_clock"}, int'(clock), 0);
    chk({tag, "_lamps"}, int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 0);
  endtask

  // Monitor: the DUT presents outputs every cycle; compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ns_green && ew_green) chk("dual_green", 1, 0);
      if (ns_green && ns_yellow) chk("ns_dual_lamp", 1, 0);
      if (ew_green && ew_yellow) chk("ew_dual_lamp", 1, 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase", int'(phase), e.ph);
        chk("clock", int'(clock), e.rem);
        chk("lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}),
            int'(exp_lamps(e.ph)));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    step(0, 0);
    @(posedge clk);
    #1;
    chk("first_cycle_phase", int'(phase), 1);
    chk("first_cycle_clock", int'(clock), A_T);
    repeat (280) step(0, 0);

`ifdef PASS_SHORTEN_EN
    run_until(2, 40);
    step(1, 0);
    step(0, 0);
    @(posedge clk);
    #1;
    chk("ns_short_load", int'(clock), S_T);

    run_until(2, 50);
    step(0, 1);
    run_until(5, 60);
    step(0, 0);
    @(posedge clk);
    #1;
    chk("ew_held_short", int'(clock), S_T);
    run_until(6, 5);

    run_until(2, 8);
    step(1, 0);
    run_until(2, 1);
    step(1, 0);
    run_until(2, 60);
    step(0, 0);
    @(posedge clk);
    #1;
    chk("last_cycle_no_carry", int'(clock), G_T - 1);
`endif

    run_until(6, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_ph  = 0;
    m_rem = 0;
    m_nq  = 0;
    m_eq  = 0;
    step(0, 0);
    @(posedge clk);
    #1;
    chk("restart_phase", int'(phase), 1);
    repeat (150) step(0, 0);

    repeat (300) step(1, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
    end
    step(0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
